// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with fixed-burst, locked-sequence and SPLIT-mask tracking.
// Round-robin by default; defining AHB_ARB_FIXED_PRIO_EN selects lowest-index static priority.
module ahb_arbiter #(
  parameter int NO_OF_MASTERS  = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0]         HLOCK,
  input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
  input  logic [1:0]                       HTRANS,
  input  logic [2:0]                       HBURST,
  input  logic                             HREADY,
  input  logic [1:0]                       HRESP,
  output logic [NO_OF_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
  output logic                             HMASTLOCK
);
  localparam int N  = NO_OF_MASTERS;
  localparam int MW = $clog2(NO_OF_MASTERS);
  localparam logic [1:0] ARB = 2'd0, BURST = 2'd1, LOCKED = 2'd2;
  logic [1:0]    state;
  logic [4:0]    cnt, len;
  logic [N-1:0]  split_mask, elig, split_set, one;
  logic [MW-1:0] g, win;
  logic          rearb, hold, load, dec;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [MW-1:0] rr;
`endif
  assign one       = {{(N-1){1'b0}}, 1'b1};
  assign elig      = HBUSREQ & ~split_mask;
  assign rearb     = state == ARB || (state == BURST && cnt == 5'd1);
  assign hold      = HLOCK[g] & HBUSREQ[g];
  assign len       = (HBURST inside {3'd2, 3'd3}) ? 5'd4 :
                     (HBURST inside {3'd4, 3'd5}) ? 5'd8 :
                     (HBURST inside {3'd6, 3'd7}) ? 5'd16 : 5'd0;
  assign load      = HTRANS == 2'd2 && len != 5'd0;
  assign dec       = HTRANS == 2'd3 && cnt != 5'd0;
  assign split_set = (!HREADY && HRESP == 2'd3) ? one << HMASTER : '0;
  always_comb begin
    g = '0;
    for (int j = 0; j < N; j++) if (HGRANT[j]) g = MW'(j);
  end
  // Lowest distance past the pointer wins; the pointer itself ranks last.
  always_comb begin
    int best, off;
    win  = MW'(DEFAULT_MASTER);
    best = N + 1;
    for (int j = 0; j < N; j++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      off = j;
`else
      off = (j + N - int'(rr)) % N;
      off = off == 0 ? N : off;
`endif
      if (elig[j] && off < best) begin
        best = off;
        win  = MW'(j);
      end
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT     <= one << DEFAULT_MASTER;
      HMASTER    <= MW'(DEFAULT_MASTER);
      HMASTLOCK  <= 1'b0;
      split_mask <= '0;
      cnt        <= 5'd0;
      state      <= ARB;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr         <= MW'(DEFAULT_MASTER);
`endif
    end else begin
      split_mask <= (split_mask & ~HSPLIT) | split_set;
      if (!HREADY) begin
        if (HRESP == 2'd2 || HRESP == 2'd3) begin
          cnt   <= 5'd0;
          state <= ARB;
        end
      end else begin
        HMASTER   <= g;
        HMASTLOCK <= HLOCK[g];
        cnt       <= load ? len : dec ? cnt - 5'd1 : cnt;
        if (state == LOCKED) state <= HLOCK[g] ? LOCKED : ARB;
        else if (rearb && hold) state <= LOCKED;
        else if (load) state <= BURST;
        else if (dec && cnt == 5'd1) state <= ARB;
        if (rearb && !hold) begin
          HGRANT <= one << win;
`ifndef AHB_ARB_FIXED_PRIO_EN
          rr     <= win;
`endif
        end
      end
    end
  end
endmodule
